// File: rtl/res_pkg.sv
// Shared defaults and helpers for the resolved open-collector bus keeper.
package res_pkg;

    localparam int RES_WIDTH_DEF = 18;
    localparam int RES_NDRV_DEF  = 2;
    localparam int RES_FILT_DEF  = 2;
    localparam int RES_STUCK_DEF = 1024;

    // Watchdog counter width: enough bits to hold the saturation value n.
    function automatic int res_cw(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/res_bus_keeper_if.sv
// Driver-side and consumer-side signals of the pulled-up bus, grouped for port use.
interface res_bus_keeper_if
    import res_pkg::*;
#(
    parameter int WIDTH = RES_WIDTH_DEF,
    parameter int NDRV  = RES_NDRV_DEF
) ();

    logic [NDRV*WIDTH-1:0] drv_low;
    logic                  release_en;
    logic                  stuck_clr;
    logic [WIDTH-1:0]      line_raw;
    logic [WIDTH-1:0]      line_q;
    logic [WIDTH-1:0]      rise;
    logic [WIDTH-1:0]      fall;
    logic [WIDTH-1:0]      stuck;

    modport master (
        output drv_low, release_en, stuck_clr,
        input  line_raw, line_q, rise, fall, stuck
    );

    modport slave (
        input  drv_low, release_en, stuck_clr,
        output line_raw, line_q, rise, fall, stuck
    );

endinterface

// File: rtl/res_line.sv
// One bus line: glitch filter, registered level, edge pulses and stuck-low watchdog.
module res_line
    import res_pkg::*;
#(
    parameter int FILT      = RES_FILT_DEF,
    parameter int STUCK_MAX = RES_STUCK_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic stuck_clr,
    output logic q,
    output logic rise,
    output logic fall,
    output logic stuck
);

    localparam int CW = res_cw(STUCK_MAX);
    localparam logic [CW-1:0] CNT_MAX = CW'(STUCK_MAX);
    localparam logic [CW-1:0] CNT_ARM = CW'(STUCK_MAX - 1);

    logic          all_hi_s;
    logic          all_lo_s;
    logic          q_q, q_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          stuck_q, stuck_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The current sample plus FILT-1 stored samples form the agreement window.
    generate
        if (FILT == 1) begin : g_nohist
            assign all_hi_s = raw;
            assign all_lo_s = ~raw;
        end else begin : g_hist
            logic [FILT-2:0] hist_q;
            logic [FILT-2:0] hist_d;

            // Shift the newest sample into the history.
            always_comb begin
                hist_d = (FILT-1)'({hist_q, raw});
            end

            // History register, preset high like an undriven line.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hist_q <= {(FILT-1){1'b1}};
                end else begin
                    hist_q <= hist_d;
                end
            end

            assign all_hi_s = raw & (&hist_q);
            assign all_lo_s = ~raw & ~(|hist_q);
        end
    endgenerate

    // Filtered level, edge pulses and watchdog next-state.
    always_comb begin
        q_d     = q_q;
        cnt_d   = cnt_q;
        stuck_d = stuck_q;
        if (all_hi_s) begin
            q_d = 1'b1;
        end else if (all_lo_s) begin
            q_d = 1'b0;
        end else begin
            q_d = q_q;
        end
        rise_d = q_d & ~q_q;
        fall_d = ~q_d & q_q;

        // stuck_clr dominates both the counter and a same-edge flag set.
        if (stuck_clr) begin
            cnt_d   = {CW{1'b0}};
            stuck_d = 1'b0;
        end else if (!q_q) begin
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + {{(CW-1){1'b0}}, 1'b1};
            stuck_d = stuck_q | (cnt_q == CNT_ARM);
        end else begin
            cnt_d   = {CW{1'b0}};
            stuck_d = stuck_q;
        end
    end

    // Line state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q     <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            stuck_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            stuck_q <= stuck_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q     = q_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign stuck = stuck_q;

endmodule

// File: rtl/res_bus_keeper.sv
// Emulated pull-up bus: wired-OR of active-low drivers per line, with release of stuck lines.
module res_bus_keeper
    import res_pkg::*;
#(
    parameter int WIDTH     = RES_WIDTH_DEF,
    parameter int NDRV      = RES_NDRV_DEF,
    parameter int FILT      = RES_FILT_DEF,
    parameter int STUCK_MAX = RES_STUCK_DEF
) (
    input  logic             clk,
    input  logic             reset,
    res_bus_keeper_if.slave  bus
);

    logic [WIDTH-1:0] pulled_s;
    logic [WIDTH-1:0] raw_s;
    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] stuck_s;

    // Resolve drivers; a released stuck line floats high regardless of drivers.
    always_comb begin
        pulled_s = {WIDTH{1'b0}};
        for (int d = 0; d < NDRV; d++) begin
            for (int i = 0; i < WIDTH; i++) begin
                pulled_s[i] = pulled_s[i] | bus.drv_low[d*WIDTH+i];
            end
        end
        raw_s = ~pulled_s | (stuck_s & {WIDTH{bus.release_en}});
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_line
            res_line #(
                .FILT      (FILT),
                .STUCK_MAX (STUCK_MAX)
            ) u_line (
                .clk       (clk),
                .reset     (reset),
                .raw       (raw_s[i]),
                .stuck_clr (bus.stuck_clr),
                .q         (q_s[i]),
                .rise      (rise_s[i]),
                .fall      (fall_s[i]),
                .stuck     (stuck_s[i])
            );
        end
    endgenerate

    assign bus.line_raw = raw_s;
    assign bus.line_q   = q_s;
    assign bus.rise     = rise_s;
    assign bus.fall     = fall_s;
    assign bus.stuck    = stuck_s;

endmodule

// File: tb/tb_res_bus_keeper.sv
// Bench for res_bus_keeper: FILT=2 and FILT=1 builds checked against a run-length reference model.
module tb_res_bus_keeper;
    import res_pkg::*;

    localparam int W  = 4;
    localparam int N  = 2;
    localparam int SM = 8;

    logic         clk;
    logic         reset;
    logic [N*W-1:0] drv;
    logic         release_en;
    logic         stuck_clr;

    res_bus_keeper_if #(.WIDTH(W), .NDRV(N)) b0 ();
    res_bus_keeper_if #(.WIDTH(W), .NDRV(N)) b1 ();

    assign b0.drv_low    = drv;
    assign b0.release_en = release_en;
    assign b0.stuck_clr  = stuck_clr;
    assign b1.drv_low    = drv;
    assign b1.release_en = release_en;
    assign b1.stuck_clr  = stuck_clr;

    res_bus_keeper #(.WIDTH(W), .NDRV(N), .FILT(2), .STUCK_MAX(SM)) dut0 (
        .clk (clk), .reset (reset), .bus (b0.slave)
    );
    res_bus_keeper #(.WIDTH(W), .NDRV(N), .FILT(1), .STUCK_MAX(SM)) dut1 (
        .clk (clk), .reset (reset), .bus (b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: per build and line, run length of identical raw samples
    // and count of consecutive low cycles of the filtered level.
    int lastv  [2][W];
    int runlen [2][W];
    int lowrun [2][W];
    bit q_m    [2][W];
    bit rise_m [2][W];
    bit fall_m [2][W];
    bit stuck_m[2][W];

    function automatic int filt_of(input int inst);
        return (inst == 0) ? 2 : 1;
    endfunction

    function automatic bit raw_of(input int inst, input int i);
        if (release_en && stuck_m[inst][i]) return 1'b1;
        return !(drv[i] || drv[W+i]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < W; i++) begin
                lastv[k][i] = 1; runlen[k][i] = 100; lowrun[k][i] = 0;
                q_m[k][i] = 1'b1; rise_m[k][i] = 1'b0; fall_m[k][i] = 1'b0;
                stuck_m[k][i] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [W-1:0] g_raw[2], g_q[2], g_r[2], g_f[2], g_s[2];
        logic [W-1:0] e_raw, e_q, e_r, e_f, e_s;
        g_raw[0] = b0.line_raw; g_q[0] = b0.line_q; g_r[0] = b0.rise; g_f[0] = b0.fall; g_s[0] = b0.stuck;
        g_raw[1] = b1.line_raw; g_q[1] = b1.line_q; g_r[1] = b1.rise; g_f[1] = b1.fall; g_s[1] = b1.stuck;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < W; i++) begin
                e_raw[i] = raw_of(k, i); e_q[i] = q_m[k][i];
                e_r[i] = rise_m[k][i]; e_f[i] = fall_m[k][i]; e_s[i] = stuck_m[k][i];
            end
            chk($sformatf("f%0d.line_raw @%0t", filt_of(k), $time), g_raw[k], e_raw);
            chk($sformatf("f%0d.line_q @%0t", filt_of(k), $time), g_q[k], e_q);
            chk($sformatf("f%0d.rise @%0t", filt_of(k), $time), g_r[k], e_r);
            chk($sformatf("f%0d.fall @%0t", filt_of(k), $time), g_f[k], e_f);
            chk($sformatf("f%0d.stuck @%0t", filt_of(k), $time), g_s[k], e_s);
        end
    endtask

    // Advance one clock: model consumes the pre-edge inputs, DUT checked after the edge.
    task automatic tick();
        bit r, qold, qn;
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < W; i++) begin
                    r = raw_of(k, i);
                    if (int'(r) == lastv[k][i]) begin
                        if (runlen[k][i] < 100) runlen[k][i]++;
                    end else begin
                        lastv[k][i] = int'(r); runlen[k][i] = 1;
                    end
                    qold = q_m[k][i];
                    qn = (runlen[k][i] >= filt_of(k)) ? (lastv[k][i] == 1) : qold;
                    rise_m[k][i] = qn && !qold;
                    fall_m[k][i] = !qn && qold;
                    if (stuck_clr) begin
                        lowrun[k][i] = 0; stuck_m[k][i] = 1'b0;
                    end else if (!qold) begin
                        if (lowrun[k][i] < SM) lowrun[k][i]++;
                        if (lowrun[k][i] == SM) stuck_m[k][i] = 1'b1;
                    end else begin
                        lowrun[k][i] = 0;
                    end
                    q_m[k][i] = qn;
                end
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) tick();
    endtask

    task automatic set_reset(input logic v);
        reset = v;
        if (v) model_reset();
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; drv = '0; release_en = 1'b0; stuck_clr = 1'b0;
        model_reset();
        #2;
        check_all();
        chk("reset.line_q_const", b0.line_q, 4'hF);
        ticks(2);
        set_reset(1'b0);
        ticks(2);

        // Glitch rejection, then a two-cycle hold that must propagate.
        drv[0] = 1'b1; tick(); drv[0] = 1'b0; ticks(3);
        drv[0] = 1'b1; ticks(2); drv[0] = 1'b0; ticks(3);

        // Wired-OR on line 2 via both drivers.
        drv[2] = 1'b1; drv[6] = 1'b1; ticks(3);
        drv[2] = 1'b0; ticks(3);
        drv[6] = 1'b0; ticks(4);

        // Mid-run asynchronous reset while line 3 is held low.
        drv[3] = 1'b1; ticks(4);
        set_reset(1'b1);
        chk("midreset.line_q_const", b0.line_q, 4'hF);
        drv[3] = 1'b0; tick();
        set_reset(1'b0);
        ticks(2);

        // Watchdog on line 1, then release and clear.
        drv[1] = 1'b1; ticks(16);
        release_en = 1'b1; #1; check_all();
        ticks(4);
        drv[1] = 1'b0; tick();
        stuck_clr = 1'b1; tick(); stuck_clr = 1'b0;
        ticks(4);

        // stuck_clr coinciding with the edge that would set stuck on the FILT=2 build.
        release_en = 1'b0; drv[1] = 1'b1;
        ticks(9);
        stuck_clr = 1'b1; tick(); stuck_clr = 1'b0;
        chk("simclr.stuck", b0.stuck, 4'h0);
        ticks(10);
        drv[1] = 1'b0; ticks(4);

        // Randomized traffic against the model.
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(3) == 0) drv = N*W'($urandom);
            if ($urandom_range(7) == 0) release_en = ~release_en;
            stuck_clr = ($urandom_range(39) == 0);
            if ($urandom_range(199) == 0) begin
                set_reset(1'b1); tick(); set_reset(1'b0);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/res_bus_keeper.md
Name: res_bus_keeper

Overview:
- Parametrised successor to the fixed 18-line pull-up resistor pack, for FPGA builds where real open-collector lines and pull-ups do not exist.
- Resolves WIDTH wired-OR, active-low bus lines, each driven by NDRV open-collector sources, with an implicit pull-up (undriven line reads 1).
- Adds a per-line glitch filter, edge pulses, and a stuck-low watchdog that can optionally release a hung line.
- Sits between bus driver logic and every consumer of the pulled-up bus signals.

Parameters:
- WIDTH, 18, number of pulled-up lines.
- NDRV, 2, open-collector drivers per line.
- FILT, 2, consecutive identical samples required before line_q changes (legal range 1..8).
- STUCK_MAX, 1024, consecutive low cycles on line_q that mark a line stuck (at least 2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- drv_low  in  NDRV*WIDTH  driver d pulls line i low when bit d*WIDTH+i is 1
- release_en  in  1  when 1, stuck lines ignore their drivers and float high
- stuck_clr  in  1  one-cycle pulse; clears all stuck flags and watchdog counters
- line_raw  out  WIDTH  combinational resolved level
- line_q  out  WIDTH  filtered, registered level
- rise  out  WIDTH  one-cycle pulse on a 0->1 change of line_q
- fall  out  WIDTH  one-cycle pulse on a 1->0 change of line_q
- stuck  out  WIDTH  sticky stuck-low flag

Behaviour:
- Reset: reset is asynchronous and active-high. While asserted:
  - line_q = all 1, rise = fall = stuck = 0.
  - Filter history = all 1, watchdog counters = 0.
- line_raw[i] = NOT (OR over d of drv_low[d*WIDTH+i]), except line_raw[i] = 1 when release_en and stuck[i] are both 1. This is purely combinational, including during reset.
- Filter, per line:
  - A FILT-deep history of line_raw samples is kept.
  - line_q[i] takes value v on the edge where the last FILT samples are all v; otherwise it holds.
  - Latency: line_raw stable from edge n appears on line_q after edge n+FILT-1, i.e. FILT cycles of stability are required.
  - Pulses shorter than FILT cycles never reach line_q.
  - With FILT=1, line_q is line_raw delayed by one register.
- Edges: rise[i] and fall[i] are registered and asserted in the same cycle line_q[i] changes, high for exactly one cycle. They are never both 1.
- Watchdog counter, per line, width clog2(STUCK_MAX+1):
  - If stuck_clr = 1: counter -> 0 (highest priority).
  - Else if line_q[i] = 0: counter increments, saturating at STUCK_MAX.
  - Else: counter -> 0.
- stuck[i]:
  - Set on the edge where the counter already equals STUCK_MAX-1 and line_q[i] = 0 and stuck_clr = 0. The flag therefore rises at the end of the STUCK_MAX-th consecutive low cycle of line_q.
  - Cleared only by stuck_clr or reset. stuck_clr wins over a same-cycle set.
  - After a clear on a line that is still low, stuck reasserts after another STUCK_MAX low cycles.
- Release loop: with release_en = 1, a stuck line's line_raw goes high immediately. line_q rises FILT cycles later, its counter clears, and stuck stays 1 (sticky).
  - Toggling release_en to 0 re-exposes the drivers. No other state changes.
- Lines are fully independent. No cross-line interaction except the shared stuck_clr and release_en.
- Reset asserted mid-count or mid-filter: all state is returned to reset values immediately (asynchronous). No pulses are emitted on reset release.
- drv_low is assumed synchronous to clk; the block adds no synchronisers.

Decomposition:
- Package res_pkg:
  - Parameter defaults: RES_WIDTH_DEF = 18, RES_NDRV_DEF = 2, RES_FILT_DEF = 2, RES_STUCK_DEF = 1024.
  - Function res_cw(n) returning the counter width.
- Sub-module res_line: one line's filter history, line_q, rise/fall, watchdog counter and stuck flag.
  - Inputs: raw bit, stuck_clr.
  - Outputs: q, rise, fall, stuck.
  - res_bus_keeper instantiates it WIDTH times in a generate loop and holds only the driver OR / release mux.

Test Plan (WIDTH=4, NDRV=2, FILT=2, STUCK_MAX=8 unless stated):
- Reset, all drivers 0:
  - Required: line_raw = 4'hF, line_q = 4'hF, no rise/fall.
  - Assert reset mid-run: line_q = 4'hF in the same cycle.
- Glitch rejection: drv_low[0] = 1 for 1 cycle -> line_raw[0] pulses low, line_q[0] stays 1, fall[0] = 0.
  - Held 2 cycles -> line_q[0] = 0 with fall[0] high one cycle, exactly 2 edges after the first low sample.
- Wired-OR: drivers 0 and 1 both pull line 2; release driver 0 only -> line_q[2] stays 0.
  - Release driver 1 -> rise[2] pulses 2 cycles later and line_q[2] = 1.
- Watchdog: hold line 1 low.
  - stuck[1] = 1 on the 8th consecutive low cycle of line_q[1], not the 7th.
  - stuck[1] stays 1 with the counter saturated at 8.
- Release: with stuck[1] = 1, set release_en.
  - line_raw[1] = 1 immediately, rise[1] after 2 cycles, stuck[1] still 1.
  - Pulse stuck_clr -> stuck[1] = 0; with release_en still 1 the line stays high.
- Simultaneous: stuck_clr on the same edge stuck would set -> stuck stays 0 and the counter restarts from 0.
  - Reasserts 8 low cycles later.
  - FILT=1 build: line_q follows line_raw with exactly 1-cycle delay.
